// File: rtl/multicycle_alu_if.sv
// Controller <-> execute-stage bundle: operands and launch request in,
// writeback triple, busy and flags out.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic [ADDR_W-1:0] dir_dest;
    logic              busy;
    logic              reg_write;
    logic [ADDR_W-1:0] dir_WR;
    logic [WIDTH-1:0]  wr_data;
    logic              flag_zero;
    logic              flag_ovf;
    logic              flag_div0;

    modport master (
        output start, op, opA, opB, dir_dest,
        input  busy, reg_write, dir_WR, wr_data, flag_zero, flag_ovf, flag_div0
    );

    modport slave (
        input  start, op, opA, opB, dir_dest,
        output busy, reg_write, dir_WR, wr_data, flag_zero, flag_ovf, flag_div0
    );
endinterface

// File: rtl/multicycle_alu.sv
// Single-issue execute stage: 1-cycle ADD/SUB/AND/OR/MOVE, WIDTH-cycle MUL/DIV/MOD.
// Define ALU_FLAGS_EN to build the zero/overflow/div0 flag registers; otherwise flags read 0.
module multicycle_alu #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
) (
    input logic             clk,
    input logic             rst,
    multicycle_alu_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpDiv = 3'b101;
    localparam logic [2:0] OpMod = 3'b110;
    localparam logic [2:0] OpMov = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    // acc: product / partial remainder; a: multiplicand / dividend->quotient; b: multiplier / divisor
    logic [WIDTH-1:0]  acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic              busy_q, busy_d, reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] dir_wr_q, dir_wr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;

    logic              wb_load;
    logic [WIDTH-1:0]  result, sum, diff, mul_acc;
    logic [ADDR_W-1:0] wb_dir;
    logic [WIDTH:0]    div_shift, div_trial;
    logic              div_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        dir_d       = dir_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        reg_write_d = 1'b0;
        dir_wr_d    = dir_wr_q;
        wr_data_d   = wr_data_q;
        wb_load     = 1'b0;
        result      = '0;
        wb_dir      = dir_q;
        sum         = bus.opA + bus.opB;
        diff        = bus.opA - bus.opB;
        mul_acc     = acc_q + (b_q[0] ? a_q : '0);
        div_shift   = {acc_q, a_q[WIDTH-1]};
        div_trial   = div_shift - {1'b0, b_q};
        div_ok      = ~div_trial[WIDTH];

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    op_d   = bus.op;
                    dir_d  = bus.dir_dest;
                    a_d    = bus.opA;
                    b_d    = bus.opB;
                    acc_d  = '0;
                    cnt_d  = '0;
                    wb_dir = bus.dir_dest;
                    unique case (bus.op)
                        OpAdd: begin result = sum;                 wb_load = 1'b1; end
                        OpSub: begin result = diff;                wb_load = 1'b1; end
                        OpAnd: begin result = bus.opA & bus.opB;   wb_load = 1'b1; end
                        OpOr:  begin result = bus.opA | bus.opB;   wb_load = 1'b1; end
                        OpMov: begin result = bus.opA;             wb_load = 1'b1; end
                        OpMul: begin
                            state_d = StExec;
                            busy_d  = 1'b1;
                        end
                        OpDiv, OpMod: begin
                            if (bus.opB == '0) begin
                                result  = (bus.op == OpDiv) ? '1 : bus.opA;
                                wb_load = 1'b1;
                            end else begin
                                state_d = StExec;
                                busy_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StExec: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OpMul) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], div_ok};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    wb_load = 1'b1;
                    result  = (op_q == OpDiv) ? a_d : acc_d;
                end
            end
            StWb: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (wb_load) begin
            state_d     = StWb;
            busy_d      = 1'b1;
            reg_write_d = 1'b1;
            wr_data_d   = result;
            dir_wr_d    = wb_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            dir_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            reg_write_q <= 1'b0;
            dir_wr_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            dir_q       <= dir_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            reg_write_q <= reg_write_d;
            dir_wr_q    <= dir_wr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.reg_write = reg_write_q;
    assign bus.dir_WR    = dir_wr_q;
    assign bus.wr_data   = wr_data_q;

`ifdef ALU_FLAGS_EN
    logic ovf_d, div0_d;
    logic flag_zero_q, flag_ovf_q, flag_div0_q;

    // Overflow and div0 can only arise from an op accepted in IDLE
    always_comb begin
        ovf_d  = 1'b0;
        div0_d = 1'b0;
        if (state_q == StIdle && bus.start) begin
            case (bus.op)
                OpAdd: ovf_d = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) &&
                               (sum[WIDTH-1] != bus.opA[WIDTH-1]);
                OpSub: ovf_d = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) &&
                               (diff[WIDTH-1] != bus.opA[WIDTH-1]);
                OpDiv, OpMod: div0_d = (bus.opB == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero_q <= 1'b0;
            flag_ovf_q  <= 1'b0;
            flag_div0_q <= 1'b0;
        end else if (wb_load) begin
            flag_zero_q <= (result == '0);
            flag_ovf_q  <= ovf_d;
            flag_div0_q <= div0_d;
        end
    end

    assign bus.flag_zero = flag_zero_q;
    assign bus.flag_ovf  = flag_ovf_q;
    assign bus.flag_div0 = flag_div0_q;
`else
    assign bus.flag_zero = 1'b0;
    assign bus.flag_ovf  = 1'b0;
    assign bus.flag_div0 = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: latency, results, handshake, reset abort, flags.
module tb_multicycle_alu;
    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpDiv = 3'b101;
    localparam logic [2:0] OpMod = 3'b110;
    localparam logic [2:0] OpMov = 3'b111;

`ifdef ALU_FLAGS_EN
    localparam logic FlagsEn = 1'b1;
`else
    localparam logic FlagsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    int   bad;

    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(32), .ADDR_W(4)) bus ();

    multicycle_alu #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d);
        bus.op       = o;
        bus.opA      = a;
        bus.opB      = b;
        bus.dir_dest = d;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic [3:0] d, input logic [31:0] data);
        check({tag, "_rw"},   32'(bus.reg_write), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy),      32'd1);
        check({tag, "_dir"},  32'(bus.dir_WR),    32'(d));
        check({tag, "_data"}, bus.wr_data,        data);
    endtask

    task automatic run_multi(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] d,
                             input logic [31:0] data);
        int early = 0;
        issue(o, a, b, d);
        repeat (32) begin
            if (bus.reg_write !== 1'b0 || bus.busy !== 1'b1) early++;
            tick();
        end
        check({tag, "_latency"}, 32'(early), 32'd0);
        check_wb(tag, d, data);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op       = OpAdd;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.dir_dest = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy),      32'd0);
        check("rst_rw",   32'(bus.reg_write), 32'd0);
        check("rst_dir",  32'(bus.dir_WR),    32'd0);
        check("rst_data", bus.wr_data,        32'd0);
        check("rst_zero", 32'(bus.flag_zero), 32'd0);
        check("rst_ovf",  32'(bus.flag_ovf),  32'd0);
        check("rst_div0", 32'(bus.flag_div0), 32'd0);
        rst = 1'b0;
        tick();

        issue(OpAdd, 32'd7, 32'd5, 4'd3);
        check_wb("add", 4'd3, 32'd12);
        check("add_zero", 32'(bus.flag_zero), 32'd0);
        check("add_ovf",  32'(bus.flag_ovf),  32'd0);
        tick();
        check("add_rw_off",   32'(bus.reg_write), 32'd0);
        check("add_busy_off", 32'(bus.busy),      32'd0);

        issue(OpSub, 32'h8000_0000, 32'd1, 4'd4);
        check_wb("sub_ovf", 4'd4, 32'h7FFF_FFFF);
        check("sub_ovf_flag", 32'(bus.flag_ovf), 32'(FlagsEn));
        tick();
        check("sub_ovf_hold", 32'(bus.flag_ovf), 32'(FlagsEn));

        issue(OpAdd, 32'hFFFF_FFFF, 32'd1, 4'd5);
        check_wb("add_wrap", 4'd5, 32'd0);
        check("add_wrap_zero", 32'(bus.flag_zero), 32'(FlagsEn));
        check("add_wrap_ovf",  32'(bus.flag_ovf),  32'd0);
        tick();

        issue(OpAdd, 32'h7FFF_FFFF, 32'd1, 4'd6);
        check_wb("add_ovf", 4'd6, 32'h8000_0000);
        check("add_ovf_flag", 32'(bus.flag_ovf), 32'(FlagsEn));
        tick();

        issue(OpAnd, 32'h0000_F0F0, 32'h0000_0FF0, 4'd1);
        check_wb("and", 4'd1, 32'h0000_00F0);
        tick();
        issue(OpOr, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2);
        check_wb("or", 4'd2, 32'h0000_FFF0);
        tick();
        issue(OpMov, 32'hDEAD_BEEF, 32'd1, 4'd14);
        check_wb("mov", 4'd14, 32'hDEAD_BEEF);
        check("mov_ovf", 32'(bus.flag_ovf), 32'd0);
        tick();

        // MUL with start pulses and operand changes while busy
        issue(OpMul, 32'h0001_0000, 32'h0001_0001, 4'd15);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (bus.reg_write !== 1'b0 || bus.busy !== 1'b1) bad++;
            if (i == 5) begin
                bus.start    = 1'b1;
                bus.op       = OpAdd;
                bus.opA      = 32'd1;
                bus.opB      = 32'd1;
                bus.dir_dest = 4'd2;
            end
            if (i == 9) bus.start = 1'b0;
            tick();
        end
        check("mul_busy_window", 32'(bad), 32'd0);
        check_wb("mul", 4'd15, 32'h0001_0000);

        // start during WB is ignored, start in the following IDLE is accepted
        bus.op       = OpAdd;
        bus.opA      = 32'd2;
        bus.opB      = 32'd3;
        bus.dir_dest = 4'd7;
        bus.start    = 1'b1;
        tick();
        check("wb_start_ignored_rw",   32'(bus.reg_write), 32'd0);
        check("wb_start_ignored_busy", 32'(bus.busy),      32'd0);
        tick();
        bus.start = 1'b0;
        check_wb("b2b_add", 4'd7, 32'd5);
        tick();

        run_multi("div", OpDiv, 32'd100, 32'd7, 4'd8, 32'd14);
        check("div_div0", 32'(bus.flag_div0), 32'd0);
        tick();
        run_multi("mod", OpMod, 32'd100, 32'd7, 4'd9, 32'd2);
        tick();

        issue(OpDiv, 32'd123, 32'd0, 4'd10);
        check_wb("div0", 4'd10, 32'hFFFF_FFFF);
        check("div0_flag", 32'(bus.flag_div0), 32'(FlagsEn));
        tick();
        issue(OpMod, 32'd123, 32'd0, 4'd11);
        check_wb("mod0", 4'd11, 32'd123);
        check("mod0_flag", 32'(bus.flag_div0), 32'(FlagsEn));
        tick();

        // Reset during EXEC cycle 10 of a MUL
        issue(OpMul, 32'd3, 32'd4, 4'd12);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(bus.busy),      32'd0);
        check("abort_rw",   32'(bus.reg_write), 32'd0);
        check("abort_dir",  32'(bus.dir_WR),    32'd0);
        check("abort_data", bus.wr_data,        32'd0);
        check("abort_div0", 32'(bus.flag_div0), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            if (bus.reg_write !== 1'b0 || bus.busy !== 1'b0) bad++;
            tick();
        end
        check("abort_no_wb", 32'(bad), 32'd0);
        issue(OpAdd, 32'd20, 32'd22, 4'd13);
        check_wb("post_rst_add", 4'd13, 32'd42);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
